// File: rtl/dot_sequencer.sv
// Sequences operand pairs from a ready/valid stream into the fma unit and captures the dot product.
// Latency: last handshake to result_valid_out is FMA_LATENCY+2 cycles; the stream is stalled (ready low) outside RUN.
module dot_sequencer #(
  parameter int WIDTH       = 16,
  parameter int FIXED_POINT = 10,
  parameter int LEN_W       = 5,
  parameter int FMA_LATENCY = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [LEN_W-1:0] len_in,
  output logic             busy_out,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic             xy_valid_in,
  output logic             xy_ready_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] c_out,
  output logic             a_valid_out,
  output logic             b_valid_out,
  output logic             c_valid_out,
  output logic             compute_out,
  input  logic [WIDTH-1:0] fma_result_in,
  output logic [WIDTH-1:0] result_out,
  output logic             result_valid_out
);

  localparam int WAIT_W = (FMA_LATENCY < 1) ? 1 : $clog2(FMA_LATENCY + 1);

  // The Q format must not claim more fractional bits than the word holds.
  if (FIXED_POINT > WIDTH) begin : g_fp_check
    $error("FIXED_POINT exceeds WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              first_q, first_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
  logic              vld_q, vld_d;
  logic              cvld_q, cvld_d;
  logic [WIDTH-1:0]  result_q, result_d;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    beat_d   = beat_q;
    first_d  = first_q;
    wait_d   = wait_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    vld_d    = 1'b0;
    cvld_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          if (len_in != '0) begin
            len_d   = len_in;
            beat_d  = '0;
            first_d = 1'b1;
            state_d = RUN;
          end else begin
            result_d = '0;
            state_d  = DONE;
          end
        end
      end
      RUN: begin
        if (xy_valid_in) begin
          a_d     = x_in;
          b_d     = y_in;
          c_d     = '0;
          vld_d   = 1'b1;
          // Only the first product seeds the accumulator, dropping any prior sum.
          cvld_d  = first_q;
          first_d = 1'b0;
          beat_d  = beat_q + LEN_W'(1);
          if (beat_q == len_q - LEN_W'(1)) begin
            wait_d  = WAIT_W'(FMA_LATENCY);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (wait_q == '0) begin
          result_d = fma_result_in;
          state_d  = DONE;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      len_q    <= '0;
      beat_q   <= '0;
      first_q  <= 1'b0;
      wait_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      vld_q    <= 1'b0;
      cvld_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      first_q  <= first_d;
      wait_q   <= wait_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      vld_q    <= vld_d;
      cvld_q   <= cvld_d;
      result_q <= result_d;
    end
  end

  assign busy_out         = (state_q != IDLE);
  assign xy_ready_out     = (state_q == RUN);
  assign result_valid_out = (state_q == DONE);
  assign a_out            = a_q;
  assign b_out            = b_q;
  assign c_out            = c_q;
  assign a_valid_out      = vld_q;
  assign b_valid_out      = vld_q;
  assign compute_out      = vld_q;
  assign c_valid_out      = cvld_q;
  assign result_out       = result_q;

endmodule

// File: tb/tb_dot_sequencer.sv
// Directed bench for dot_sequencer driving a behavioural Q6.10 multiply-accumulate model.
module tb_dot_sequencer;

  localparam int WIDTH = 16;
  localparam int FP    = 10;
  localparam int LEN_W = 5;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             start_in;
  logic [LEN_W-1:0] len_in;
  logic             busy_out;
  logic [WIDTH-1:0] x_in, y_in;
  logic             xy_valid_in;
  logic             xy_ready_out;
  logic [WIDTH-1:0] a_out, b_out, c_out;
  logic             a_valid_out, b_valid_out, c_valid_out;
  logic             compute_out;
  logic [WIDTH-1:0] fma_result_in;
  logic [WIDTH-1:0] result_out;
  logic             result_valid_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_compute = 0;
  int n_cvalid  = 0;
  int n_valid   = 0;
  int bad_c     = 0;

  always #5 clk_in = ~clk_in;

  dot_sequencer #(.WIDTH(WIDTH), .FIXED_POINT(FP), .LEN_W(LEN_W), .FMA_LATENCY(1)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .len_in(len_in),
    .busy_out(busy_out), .x_in(x_in), .y_in(y_in), .xy_valid_in(xy_valid_in),
    .xy_ready_out(xy_ready_out), .a_out(a_out), .b_out(b_out), .c_out(c_out),
    .a_valid_out(a_valid_out), .b_valid_out(b_valid_out), .c_valid_out(c_valid_out),
    .compute_out(compute_out), .fma_result_in(fma_result_in), .result_out(result_out),
    .result_valid_out(result_valid_out)
  );

  // Behavioural fma: one-cycle latency, c_valid replaces the accumulator with c.
  logic [WIDTH-1:0] acc;
  logic [31:0]      prod;
  assign prod          = 32'(a_out) * 32'(b_out);
  assign fma_result_in = acc;
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) acc <= '0;
    else if (compute_out) acc <= (c_valid_out ? c_out : acc) + prod[FP+WIDTH-1:FP];
  end

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (compute_out) n_compute <= n_compute + 1;
    if (c_valid_out) n_cvalid <= n_cvalid + 1;
    if (c_valid_out && !compute_out) bad_c <= bad_c + 1;
    if (result_valid_out) n_valid <= n_valid + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic start_op(input logic [LEN_W-1:0] n);
    start_in = 1'b1;
    len_in   = n;
    step();
    start_in = 1'b0;
    len_in   = 5'd31;
  endtask

  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    xy_valid_in = 1'b1;
    x_in        = x;
    y_in        = y;
    step();
    xy_valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!result_valid_out && n < 50) begin
      step();
      n++;
    end
    chk("valid_seen", 32'(result_valid_out), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c0;
    int nv;
    int nc;
    rst_n_in    = 1'b0;
    start_in    = 1'b0;
    len_in      = '0;
    xy_valid_in = 1'b0;
    x_in        = '0;
    y_in        = '0;
    step();
    step();
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_ready", 32'(xy_ready_out), 0);
    chk("rst_compute", 32'(compute_out), 0);
    chk("rst_cvalid", 32'(c_valid_out), 0);
    chk("rst_avalid", 32'(a_valid_out), 0);
    chk("rst_result", 32'(result_out), 0);
    chk("rst_rvalid", 32'(result_valid_out), 0);
    chk("rst_a", 32'(a_out), 0);
    rst_n_in = 1'b1;
    step();
    chk("idle_busy", 32'(busy_out), 0);

    // Single pair: 2 * 1.5 = 3
    start_op(1);
    chk("s_busy", 32'(busy_out), 1);
    chk("s_ready", 32'(xy_ready_out), 1);
    send(16'h0800, 16'h0600);
    chk("s_compute", 32'(compute_out), 1);
    chk("s_cvalid", 32'(c_valid_out), 1);
    chk("s_ab_valid", {30'd0, a_valid_out, b_valid_out}, 32'd3);
    chk("s_a", 32'(a_out), 32'h0800);
    chk("s_b", 32'(b_out), 32'h0600);
    chk("s_c", 32'(c_out), 0);
    chk("s_ready_drain", 32'(xy_ready_out), 0);
    wait_valid(n);
    chk("s_latency", 32'(n), 32'd2);
    chk("s_result", 32'(result_out), 32'h0C00);
    step();
    chk("s_pulse_end", 32'(result_valid_out), 0);
    chk("s_busy_end", 32'(busy_out), 0);

    // Two pairs back to back: 2*1.5 + 1.25*4 = 8
    start_op(2);
    c0 = cyc;
    send(16'h0800, 16'h0600);
    chk("t_cvalid1", 32'(c_valid_out), 1);
    xy_valid_in = 1'b1;
    send(16'h0500, 16'h1000);
    chk("t_compute2", 32'(compute_out), 1);
    chk("t_cvalid2", 32'(c_valid_out), 0);
    wait_valid(n);
    chk("t_latency", 32'(n), 32'd2);
    chk("t_cycles", 32'(cyc - c0), 32'd4);
    chk("t_result", 32'(result_out), 32'h2000);
    step();

    // Immediate repeat must not carry the previous sum
    start_op(1);
    send(16'h0400, 16'h0400);
    wait_valid(n);
    chk("r_result", 32'(result_out), 32'h0400);
    step();

    // Stall three cycles between beats
    start_op(2);
    c0 = cyc;
    send(16'h0800, 16'h0600);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_gap_compute", 32'(compute_out), 0);
      chk("st_gap_cvalid", 32'(c_valid_out), 0);
    end
    send(16'h0500, 16'h1000);
    chk("st_compute2", 32'(compute_out), 1);
    wait_valid(n);
    chk("st_cycles", 32'(cyc - c0), 32'd7);
    chk("st_result", 32'(result_out), 32'h2000);
    step();

    // len=0: immediate zero result, no fma activity
    nc = n_compute;
    nv = n_valid;
    start_op(0);
    chk("z_rvalid", 32'(result_valid_out), 1);
    chk("z_result", 32'(result_out), 0);
    chk("z_busy", 32'(busy_out), 1);
    step();
    chk("z_pulse_end", 32'(result_valid_out), 0);
    chk("z_busy_end", 32'(busy_out), 0);
    chk("z_no_compute", 32'(n_compute - nc), 0);
    chk("z_one_pulse", 32'(n_valid - nv), 1);

    // start pulsed during RUN is ignored
    nv = n_valid;
    start_op(2);
    send(16'h0800, 16'h0600);
    start_in = 1'b1;
    len_in   = 5'd1;
    step();
    start_in = 1'b0;
    chk("i_busy", 32'(busy_out), 1);
    chk("i_ready", 32'(xy_ready_out), 1);
    send(16'h0500, 16'h1000);
    wait_valid(n);
    chk("i_result", 32'(result_out), 32'h2000);
    step();
    chk("i_busy_end", 32'(busy_out), 0);
    step();
    chk("i_not_queued", 32'(busy_out), 0);
    chk("i_one_pulse", 32'(n_valid - nv), 1);

    // Reset mid-RUN aborts with no pulse
    start_op(2);
    send(16'h0800, 16'h0600);
    step();
    nv = n_valid;
    #2 rst_n_in = 1'b0;
    #1;
    chk("a_busy", 32'(busy_out), 0);
    chk("a_ready", 32'(xy_ready_out), 0);
    chk("a_compute", 32'(compute_out), 0);
    chk("a_a", 32'(a_out), 0);
    chk("a_result", 32'(result_out), 0);
    chk("a_rvalid", 32'(result_valid_out), 0);
    step();
    step();
    rst_n_in = 1'b1;
    repeat (4) step();
    chk("a_no_pulse", 32'(n_valid - nv), 0);
    chk("a_idle", 32'(busy_out), 0);
    start_op(1);
    send(16'h0800, 16'h0600);
    wait_valid(n);
    chk("a2_latency", 32'(n), 32'd2);
    chk("a2_result", 32'(result_out), 32'h0C00);
    step();

    chk("cvalid_without_compute", 32'(bad_c), 0);
    chk("cvalid_count", 32'(n_cvalid), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dot_sequencer.md
# dot_sequencer

Control stage directly upstream of the `fma` unit. It accepts a start command with a vector length, pulls operand pairs from a ready/valid stream, and drives `fma`'s a/b/c/valid/compute inputs. The first product of each dot product clears the accumulator, so no sum carries over from the previous one. It waits out the `fma` latency, captures the accumulated result, and presents it with a one-cycle valid pulse. Data format is unsigned Q(WIDTH−FIXED_POINT).FIXED_POINT, identical to `fma`.

## Interface
- WIDTH, 16, operand/result width
- FIXED_POINT, 10, fractional bits (passed through to the testbench; the block does no arithmetic)
- LEN_W, 5, width of length field (max length 2^LEN_W−1)
- FMA_LATENCY, 1, cycles from compute asserted at `fma` to result visible on `fma_result_in`
---
- clk_in  in  1  single clock, rising edge
- rst_n_in  in  1  asynchronous, active-low reset
- start_in  in  1  start a dot product; sampled only in IDLE
- len_in  in  LEN_W  number of operand pairs; sampled with start_in
- busy_out  out  1  high in every state except IDLE
- x_in, y_in  in  WIDTH  operand pair
- xy_valid_in  in  1  operand pair valid
- xy_ready_out  out  1  block accepts a pair (high only in RUN)
- a_out, b_out, c_out  out  WIDTH  to fma a/b/c
- a_valid_out, b_valid_out, c_valid_out  out  1  to fma valid strobes
- compute_out  out  1  to fma compute
- fma_result_in  in  WIDTH  fma out
- result_out  out  WIDTH  captured dot product
- result_valid_out  out  1  one-cycle pulse

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Reset values:
  - All outputs 0; state IDLE; counters 0.
  - Reset asserted mid-operation aborts the operation and discards the partial sum. No result_valid pulse is produced.
- IDLE:
  - start_in=1 with len_in≠0: latch length, beat count←0, first←1, go to RUN.
  - start_in=1 with len_in=0: result_out←0, go to DONE. No fma activity.
- RUN:
  - xy_ready_out=1. A handshake is xy_valid_in & xy_ready_out.
  - On a handshake, register:
    - a_out←x_in, b_out←y_in
    - a_valid_out=b_valid_out=compute_out←1
    - c_out←0, c_valid_out←first
    - first←0, beat count+1
  - On a cycle with no handshake, compute_out, a/b/c_valid_out←0. This stalls fma; its accumulator holds.
  - Handshake on the final beat (count = latched length − 1): go to DRAIN, load wait counter←FMA_LATENCY.
- DRAIN:
  - xy_ready_out=0. The final compute pulse issues in the first DRAIN cycle.
  - Wait counter decrements each cycle.
  - When the counter reaches 0: result_out←fma_result_in, go to DONE.
- DONE: result_valid_out=1 for exactly one cycle, then IDLE.
- start_in outside IDLE is ignored (not queued).
- len_in is sampled only at start; later changes have no effect.
- Sum overflow wraps inside fma. This block does not detect it.

## Timing
- Handshake in cycle t → compute_out high in t+1 → fma result visible in t+1+FMA_LATENCY.
- Last handshake in cycle t → result_out captured at the end of t+1+FMA_LATENCY → result_valid_out high in t+2+FMA_LATENCY. With the default latency, that is t+3.
- busy_out rises the cycle after start is accepted and falls the cycle after result_valid_out.
- Minimum gap from result_valid_out to the next accepted start is 1 cycle, because IDLE must be re-entered.
- Throughput is one pair per cycle with xy_valid_in held high. A len-N operation takes N+FMA_LATENCY+3 cycles from start to returning to IDLE.
- c_valid_out is high only on the first compute of each operation. It is never high without compute_out.

## Test plan
Drive `fma` (WIDTH=16, FIXED_POINT=10) from the block.
- Single pair: start, len=1, x=0x0800 (2), y=0x0600 (1.5) → result_out=0x0C00 (3), valid pulse 3 cycles after the handshake, c_valid_out=1 on that compute.
- Two-pair dot product: [2, 1.25]·[1.5, 4], i.e. x=0x0800,0x0500 and y=0x0600,0x1000, valid held high → result 0x2000 (8). Immediately repeat with len=1, 0x0400×0x0400 → 0x0400, not 0x2400, so the previous sum is cleared.
- Stall: same two-pair vector with xy_valid_in low for 3 cycles between beats → compute_out low during the gaps, result still 0x2000, valid pulse delayed by 3 cycles.
- len=0 start → result_out=0, one valid pulse, compute_out never asserted.
- start_in pulsed while in RUN → ignored, current result unchanged. Reset asserted during RUN → all outputs 0 immediately, IDLE, no valid pulse. Next len=1, 2×1.5 → 0x0C00.
